// File: rtl/booth_result_fifo_if.sv
// booth_result_fifo_if
// Result handshake between the Booth result FIFO and its SoC-side consumer.
// The FIFO drives the head product and its valid flag. The consumer drives
// ready to accept the head entry.
interface booth_result_fifo_if #(
  parameter int DATA_SIZE = 8
);
  logic [2*DATA_SIZE-1:0] result_o;
  logic                   result_valid_o;
  logic                   result_ready_i;

  // FIFO side: presents the head entry and observes consumer acceptance
  modport master (
    output result_o,
    output result_valid_o,
    input  result_ready_i
  );

  // Consumer side: observes the head entry and signals acceptance
  modport slave (
    input  result_o,
    input  result_valid_o,
    output result_ready_i
  );
endinterface

// File: rtl/booth_result_fifo.sv
// booth_result_fifo
// Captures each finished Booth product on the rising edge of the multiplier's
// valid level and queues it in a first-word-fall-through FIFO. The FIFO has
// no bypass path, so a product written into an empty FIFO appears at the head
// on the following cycle.
// The full and overflow flags let the Booth controller hold back 'finish'
// until space is free.
// Optional feature: define BOOTH_RES_STATS_EN to add drop_count_o, an 8-bit
// counter of dropped products that saturates at 255.
module booth_result_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [2*DATA_SIZE-1:0]     booth_product_i,
  input  logic                       booth_valid_i,
  input  logic                       clear_i,
  booth_result_fifo_if.master        res_if,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o
`ifdef BOOTH_RES_STATS_EN
  ,
  output logic [7:0]                 drop_count_o
`endif
);

  localparam int PW = 2 * DATA_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          valid_q;
  logic          overflow_q;

  logic          push;
  logic          pop;
  logic          is_full;
  logic          is_empty;
  logic          wr_en;
  logic          drop;

  // Flags and handshake terms are taken from the registered state. A write
  // into a full FIFO is allowed only when the head leaves in the same cycle.
  always_comb begin
    is_full  = (level == LEVEL_FULL);
    is_empty = (level == LW'(0));
    push     = booth_valid_i & ~valid_q;
    pop      = ~is_empty & res_if.result_ready_i;
    wr_en    = push & (~is_full | pop);
    drop     = push & is_full & ~pop;
  end

  // Edge detector on the valid level. It starts from 0 after reset or clear,
  // so a valid level that is already high counts as a new product.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= booth_valid_i;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  // clear_i overrides any push or pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !wr_en) begin
        level <= level - LW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage array. Products are stored bit-exact, with no sign handling.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clear_i && wr_en) begin
      mem[wr_ptr] <= booth_product_i;
    end
  end

`ifdef BOOTH_RES_STATS_EN
  logic [7:0] drop_count_q;

  // Saturating count of products dropped because the FIFO was full
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      drop_count_q <= 8'd0;
    end else if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign drop_count_o = drop_count_q;
`endif

  // Outputs are decoded only from registered state. The head value is held
  // at 0 while the FIFO is empty.
  assign res_if.result_o       = is_empty ? '0 : mem[rd_ptr];
  assign res_if.result_valid_o = ~is_empty;
  assign full_o                = is_full;
  assign empty_o               = is_empty;
  assign level_o               = level;
  assign overflow_o            = overflow_q;

endmodule

// File: tb/tb_booth_result_fifo.sv
// tb_booth_result_fifo
// Directed, table-driven bench for booth_result_fifo with DATA_SIZE=8 and
// DEPTH=4. It also checks drop_count_o when BOOTH_RES_STATS_EN is defined.
module tb_booth_result_fifo;
  localparam int DS = 8;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        bvalid;
  logic [15:0] bprod;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        ovf;
`ifdef BOOTH_RES_STATS_EN
  logic [7:0]  dcnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        clr;
    logic        v;
    logic        r;
    logic [15:0] p;
    logic [15:0] er;
    logic [2:0]  el;
    logic        eo;
    logic [7:0]  ed;
  } vec_t;

  vec_t vt[$];

  booth_result_fifo_if #(.DATA_SIZE(DS)) rif ();

  booth_result_fifo #(.DATA_SIZE(DS), .DEPTH(DP)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .booth_product_i (bprod),
    .booth_valid_i   (bvalid),
    .clear_i         (clear),
    .res_if          (rif.master),
    .full_o          (full),
    .empty_o         (empty),
    .level_o         (level),
    .overflow_o      (ovf)
`ifdef BOOTH_RES_STATS_EN
    ,
    .drop_count_o    (dcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, cross one rising edge, then settle 1 time unit past the edge.
  task automatic step(input logic rst, input logic clr, input logic v, input logic r, input logic [15:0] p);
    reset = rst;
    clear = clr;
    bvalid = v;
    rif.result_ready_i = r;
    bprod = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [15:0] er, input logic [2:0] el,
                             input logic eo, input logic [7:0] ed);
    chk({tag, " result"}, 32'(rif.result_o), 32'(er));
    chk({tag, " valid"}, 32'(rif.result_valid_o), 32'(el != 3'd0));
    chk({tag, " level"}, 32'(level), 32'(el));
    chk({tag, " full"}, 32'(full), 32'(el == 3'd4));
    chk({tag, " empty"}, 32'(empty), 32'(el == 3'd0));
    chk({tag, " overflow"}, 32'(ovf), 32'(eo));
`ifdef BOOTH_RES_STATS_EN
    chk({tag, " drops"}, 32'(dcnt), 32'(ed));
`else
    if (ed > 8'd255) $display("unreachable");
`endif
  endtask

  task automatic add(input logic rst, input logic clr, input logic v, input logic r, input logic [15:0] p,
                     input logic [15:0] er, input logic [2:0] el, input logic eo, input logic [7:0] ed);
    vec_t e;
    e.rst = rst; e.clr = clr; e.v = v; e.r = r; e.p = p;
    e.er = er; e.el = el; e.eo = eo; e.ed = ed;
    vt.push_back(e);
  endtask

  initial begin
    // Single product with valid held high for 5 cycles
    add(0,0,1,1,16'hFFF2, 16'hFFF2,3'd1,0,8'd0);
    add(0,0,1,1,16'hFFF2, 16'h0000,3'd0,0,8'd0);
    add(0,0,1,1,16'hFFF2, 16'h0000,3'd0,0,8'd0);
    add(0,0,1,1,16'hFFF2, 16'h0000,3'd0,0,8'd0);
    add(0,0,1,1,16'hFFF2, 16'h0000,3'd0,0,8'd0);
    add(0,0,0,1,16'h0000, 16'h0000,3'd0,0,8'd0);
    // Fill with ready low
    add(0,0,1,0,16'h0001, 16'h0001,3'd1,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h0001,3'd1,0,8'd0);
    add(0,0,1,0,16'h0010, 16'h0001,3'd2,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h0001,3'd2,0,8'd0);
    add(0,0,1,0,16'h0100, 16'h0001,3'd3,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h0001,3'd3,0,8'd0);
    add(0,0,1,0,16'h1000, 16'h0001,3'd4,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h0001,3'd4,0,8'd0);
    // Overflow: product 0x7FFF is dropped
    add(0,0,1,0,16'h7FFF, 16'h0001,3'd4,1,8'd1);
    add(0,0,0,0,16'h0000, 16'h0001,3'd4,1,8'd1);
    // Full with simultaneous pop, then drain: 0x7FFF never appears
    add(0,0,1,1,16'hABCD, 16'h0010,3'd4,1,8'd1);
    add(0,0,0,1,16'h0000, 16'h0100,3'd3,1,8'd1);
    add(0,0,0,1,16'h0000, 16'h1000,3'd2,1,8'd1);
    add(0,0,0,1,16'h0000, 16'hABCD,3'd1,1,8'd1);
    add(0,0,0,1,16'h0000, 16'h0000,3'd0,1,8'd1);
    // Two entries, then clear together with a push
    add(0,0,1,0,16'h1111, 16'h1111,3'd1,1,8'd1);
    add(0,0,0,0,16'h0000, 16'h1111,3'd1,1,8'd1);
    add(0,0,1,0,16'h2222, 16'h1111,3'd2,1,8'd1);
    add(0,0,0,0,16'h0000, 16'h1111,3'd2,1,8'd1);
    add(0,1,1,0,16'h3333, 16'h0000,3'd0,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h0000,3'd0,0,8'd0);
    // Fill, overflow, then reset together with a push
    add(0,0,1,0,16'h1111, 16'h1111,3'd1,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h1111,3'd1,0,8'd0);
    add(0,0,1,0,16'h2222, 16'h1111,3'd2,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h1111,3'd2,0,8'd0);
    add(0,0,1,0,16'h3333, 16'h1111,3'd3,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h1111,3'd3,0,8'd0);
    add(0,0,1,0,16'h4444, 16'h1111,3'd4,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h1111,3'd4,0,8'd0);
    add(0,0,1,0,16'h5555, 16'h1111,3'd4,1,8'd1);
    add(0,0,0,0,16'h0000, 16'h1111,3'd4,1,8'd1);
    add(1,0,1,0,16'h6666, 16'h0000,3'd0,0,8'd0);
    add(0,0,0,0,16'h0000, 16'h0000,3'd0,0,8'd0);
    // Valid already high when reset deasserts counts as an edge
    add(1,0,1,0,16'h0042, 16'h0000,3'd0,0,8'd0);
    add(0,0,1,0,16'h0042, 16'h0042,3'd1,0,8'd0);
    add(0,0,0,1,16'h0000, 16'h0000,3'd0,0,8'd0);
    // Negative product stored bit-exact
    add(0,0,1,0,16'h8001, 16'h8001,3'd1,0,8'd0);
    add(0,0,0,1,16'h0000, 16'h0000,3'd0,0,8'd0);

    // Reset state
    step(1,0,0,0,16'h0);
    step(1,0,0,0,16'h0);
    check_state("reset", 16'h0, 3'd0, 1'b0, 8'd0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].clr, vt[i].v, vt[i].r, vt[i].p);
      check_state($sformatf("vec%0d", i), vt[i].er, vt[i].el, vt[i].eo, vt[i].ed);
    end

    // Wrap-around: 10 push/pop pairs with values 1..10
    for (int i = 1; i <= 10; i++) begin
      step(0,0,1,0,16'(i));
      check_state($sformatf("wrap_push%0d", i), 16'(i), 3'd1, 1'b0, 8'd0);
      step(0,0,0,1,16'h0);
      check_state($sformatf("wrap_pop%0d", i), 16'h0, 3'd0, 1'b0, 8'd0);
    end

    // Streaming: a push and a pop in the same cycle while the FIFO holds one entry
    step(0,0,1,0,16'h0101);
    step(0,0,0,0,16'h0);
    for (int i = 2; i <= 6; i++) begin
      step(0,0,1,1,16'h0100 + 16'(i));
      check_state($sformatf("stream%0d", i), 16'h0100 + 16'(i), 3'd1, 1'b0, 8'd0);
      step(0,0,0,0,16'h0);
    end
    step(0,0,0,1,16'h0);
    check_state("stream_end", 16'h0, 3'd0, 1'b0, 8'd0);

    // Saturation of the drop counter after 300 dropped products
    for (int i = 1; i <= 4; i++) begin
      step(0,0,1,0,16'(16'h0A00 + i));
      step(0,0,0,0,16'h0);
    end
    for (int i = 0; i < 300; i++) begin
      step(0,0,1,0,16'h7FFF);
      step(0,0,0,0,16'h0);
    end
    check_state("saturate", 16'h0A01, 3'd4, 1'b1, 8'd255);
    step(0,1,0,0,16'h0);
    check_state("sat_clear", 16'h0, 3'd0, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_result_fifo.md
# booth_result_fifo

Downstream consumer of the Booth multiplier datapath. Captures each finished product on the rising edge of the multiplier's valid level and queues it in a small first-word-fall-through FIFO. Delivers products to the SoC side over a valid/ready handshake, and reports full/overflow so the Booth controller can hold `finish` until space exists.

## Interface
Parameters:
- `DATA_SIZE`, 8: operand width of the multiplier; product width is 2*DATA_SIZE.
- `DEPTH`, 4: FIFO entries; power of two, >= 2.

Ports:
- `clk_i` input 1: single clock, all logic on rising edge.
- `reset_i` input 1: reset, synchronous, active-high.
- `booth_product_i` input 2*DATA_SIZE: product from the multiplier datapath, signed two's complement.
- `booth_valid_i` input 1: level from the multiplier; high while a product is final.
- `clear_i` input 1: synchronous flush of FIFO contents and flags.
- `result_o` output 2*DATA_SIZE: head-of-FIFO product; forced to 0 when empty.
- `result_valid_o` output 1: head entry present.
- `result_ready_i` input 1: consumer accepts the head this cycle.
- `full_o` output 1: level == DEPTH.
- `empty_o` output 1: level == 0.
- `level_o` output $clog2(DEPTH)+1: entries held.
- `overflow_o` output 1: sticky; a product was dropped.
- `drop_count_o` output 8: saturating count of dropped products; present only with `BOOTH_RES_STATS_EN`.

## Operation
- Edge detect: register `valid_q` <= `booth_valid_i`. `push` = `booth_valid_i & ~valid_q`. One capture per product, however long the valid level is held.
- `pop` = `result_valid_o & result_ready_i`.
- Storage: DEPTH x 2*DATA_SIZE register array with read/write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. `level` is tracked separately.
- Push when not full: write at wr_ptr, wr_ptr+1, level+1.
- Push when full with pop in the same cycle: accepted. Write and read both happen and level is unchanged.
- Push when full without pop: product dropped and `overflow_o` <= 1. With `BOOTH_RES_STATS_EN`, `drop_count` increments and saturates at 255.
- Pop when empty cannot occur, because `result_valid_o` = ~empty. There is no bypass path: a push into an empty FIFO is visible only the next cycle.
- Pop alone: rd_ptr+1, level-1.
- `clear_i`: pointers, level, `overflow_o`, `drop_count` and `valid_q` go to 0. Any push or pop in the same cycle is ignored. `clear_i` has priority over everything except `reset_i`.
- The product is stored bit-exact; no sign handling is applied here.
- State (informal): EMPTY (level 0), PARTIAL, FULL (level DEPTH). Transitions follow the level arithmetic above.

## Timing
- Reset values: `result_o` 0, `result_valid_o` 0, `empty_o` 1, `full_o` 0, `level_o` 0, `overflow_o` 0, `drop_count_o` 0, `valid_q` 0.
- If `booth_valid_i` is already high when reset deasserts, it counts as a rising edge. One push occurs in the first cycle after reset.
- Latency: a push sampled at edge N gives `result_valid_o`=1 and `result_o` = product after edge N (one cycle).
- Throughput: one push and one pop per cycle.
- `result_o` and `result_valid_o` are stable while `result_ready_i` is low.
- `full_o`, `empty_o` and `level_o` are registered-derived and update the cycle after a push or pop.
- Reset asserted mid-operation discards all entries on that edge.

## Configuration
- `BOOTH_RES_STATS_EN` defined: the `drop_count_o` port and its 8-bit saturating counter exist. The counter is cleared by reset and by `clear_i`.
- `BOOTH_RES_STATS_EN` undefined: the port and counter are absent. `overflow_o` alone reports drops. All other behaviour is identical.

## Test plan
- Single product: product 0xFFF2 (7 x -2), valid held high 5 cycles, ready=1 -> exactly one `result_valid_o` pulse of 1 cycle with `result_o`=0xFFF2; level returns to 0.
- Fill and order: 4 valid pulses carrying 0x0001, 0x0010, 0x0100, 0x1000 with ready=0 -> `full_o`=1, `level_o`=4. Then ready=1 -> pops in the same order over 4 cycles, `empty_o`=1 after.
- Overflow: FIFO full, ready=0, fifth pulse with 0x7FFF -> `overflow_o`=1, level stays 4, and 0x7FFF is never output. With the macro, `drop_count_o`=1; 300 such pulses -> 255.
- Full with simultaneous pop: full, ready=1 in the same cycle as a push of 0xABCD -> level stays 4, and 0xABCD is output fifth.
- Clear and reset: 2 entries plus overflow set, then `clear_i`=1 for one cycle concurrent with a push -> level 0, overflow 0, nothing captured. Repeat with `reset_i` -> identical result.
- Wrap-around: 10 push/pop pairs through DEPTH=4 with incrementing values 1..10 -> outputs 1..10 in order, with no duplication or loss.
